// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with run/pause/done control.
// Counts a loaded (digit-clamped) BCD value down on tick strobes; optional auto-reload.
module bcd_countdown_timer #(
  parameter int DIGITS      = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  tick,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
  input  logic                  start,
  input  logic                  pause,
  output logic [4*DIGITS-1:0]   qout,
  output logic                  tc,
  output logic                  busy,
  output logic                  done,
  output logic                  done_p
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   qout_q, qout_d;
  logic [W-1:0]   reload_q, reload_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           done_p_q, done_p_d;

  logic [W-1:0]   din_clamped;
  logic [W-1:0]   qout_dec;
  logic           qout_is_zero;
  logic           qout_is_one;

  assign qout_is_zero = (qout_q == '0);
  assign qout_is_one  = (qout_q == {{(W-1){1'b0}}, 1'b1});

  always_comb begin
    din_clamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      din_clamped[4*i +: 4] = (din[4*i +: 4] > 4'd9) ? 4'd9 : din[4*i +: 4];
    end
  end

  // Ripple-borrow BCD decrement: a zero digit wraps to 9 and passes the borrow upward.
  always_comb begin
    logic borrow;
    borrow   = 1'b1;
    qout_dec = qout_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (qout_q[4*i +: 4] == 4'd0) begin
          qout_dec[4*i +: 4] = 4'd9;
        end else begin
          qout_dec[4*i +: 4] = qout_q[4*i +: 4] - 4'd1;
          borrow             = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    qout_d   = qout_q;
    reload_d = reload_q;
    done_p_d = 1'b0;

    if (load) begin
      qout_d   = din_clamped;
      reload_d = din_clamped;
      state_d  = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (qout_is_zero) begin
              state_d  = DONE;
              done_p_d = 1'b1;
            end else begin
              state_d  = RUN;
            end
          end
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (tick) begin
            if (qout_is_one) begin
              done_p_d = 1'b1;
              if (AUTO_RELOAD && (reload_q != '0)) begin
                qout_d = reload_q;
              end else begin
                qout_d  = '0;
                state_d = DONE;
              end
            end else if (!qout_is_zero) begin
              qout_d = qout_dec;
            end
          end
        end
        PAUSE: begin
          if (start && !pause) begin
            state_d = RUN;
          end
        end
        DONE: begin
          qout_d = '0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d == RUN) || (state_d == PAUSE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      qout_q   <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      done_p_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      qout_q   <= qout_d;
      reload_q <= reload_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      done_p_q <= done_p_d;
    end
  end

  assign qout   = qout_q;
  assign tc     = qout_is_zero;
  assign busy   = busy_q;
  assign done   = done_q;
  assign done_p = done_p_q;

endmodule
